// File: rtl/hermes_switch_control.sv
// Hermes router switch control: round-robin header arbitration, XY routing,
// output port allocation and release of connections when packets finish.
module hermes_switch_control #(
  parameter int unsigned FLIT_SIZE  = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  localparam int unsigned NPORT = 5,
  localparam int unsigned PW    = 3
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [2*ADDR_WIDTH-1:0]         address_i,
  input  logic [NPORT-1:0]                req_i,
  input  logic [NPORT-1:0][FLIT_SIZE-1:0] header_i,
  input  logic [NPORT-1:0]                sending_i,
  output logic [NPORT-1:0]                ack_h_o,
  output logic [NPORT-1:0]                free_o,
  output logic [NPORT-1:0][PW-1:0]        inport_o,
  output logic [NPORT-1:0][PW-1:0]        outport_o
);

  localparam logic [PW-1:0] EAST  = 3'd0;
  localparam logic [PW-1:0] WEST  = 3'd1;
  localparam logic [PW-1:0] NORTH = 3'd2;
  localparam logic [PW-1:0] SOUTH = 3'd3;
  localparam logic [PW-1:0] LOCAL = 3'd4;

  typedef enum logic [1:0] {IDLE, ARB, ROUTE, GRANT} state_t;

  state_t                   state_q, state_d;
  logic [PW-1:0]            sel_q, sel_d;
  logic [PW-1:0]            ptr_q, ptr_d;
  logic [PW-1:0]            dst_q, dst_d;
  logic [NPORT-1:0]         active_q, active_d;
  logic [NPORT-1:0]         sending_q;
  logic [NPORT-1:0]         ack_d;
  logic [NPORT-1:0]         free_d;
  logic [NPORT-1:0][PW-1:0] inport_d;
  logic [NPORT-1:0][PW-1:0] outport_d;

  logic [PW-1:0]            rr_sel_c;
  logic                     rr_found_c;
  logic [PW-1:0]            route_c;
  logic [FLIT_SIZE-1:0]     hdr_c;
  logic [ADDR_WIDTH-1:0]    tx_c, ty_c, mx_c, my_c;
  logic                     unused_hdr_c;

  // Round-robin search starting one past the last served input
  always_comb begin
    rr_found_c = 1'b0;
    rr_sel_c   = ptr_q;
    for (int unsigned k = 1; k <= NPORT; k++) begin
      int unsigned idx;
      idx = (32'(ptr_q) + k) % NPORT;
      if (!rr_found_c && req_i[idx]) begin
        rr_found_c = 1'b1;
        rr_sel_c   = PW'(idx);
      end
    end
  end

  assign hdr_c        = header_i[sel_q];
  assign tx_c         = hdr_c[2*ADDR_WIDTH-1:ADDR_WIDTH];
  assign ty_c         = hdr_c[ADDR_WIDTH-1:0];
  assign mx_c         = address_i[2*ADDR_WIDTH-1:ADDR_WIDTH];
  assign my_c         = address_i[ADDR_WIDTH-1:0];
  assign unused_hdr_c = ^hdr_c[FLIT_SIZE-1:2*ADDR_WIDTH];

  // XY routing: resolve X first, then Y
  always_comb begin
    if (tx_c > mx_c)      route_c = EAST;
    else if (tx_c < mx_c) route_c = WEST;
    else if (ty_c > my_c) route_c = NORTH;
    else if (ty_c < my_c) route_c = SOUTH;
    else                  route_c = LOCAL;
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    dst_d     = dst_q;
    ack_d     = '0;
    free_d    = free_o;
    inport_d  = inport_o;
    outport_d = outport_o;
    active_d  = active_q;

    // Falling edge of sending on an active input frees its output
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (active_q[i] && sending_q[i] && !sending_i[i]) begin
        free_d[inport_o[i]] = 1'b1;
        active_d[i]         = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (|req_i) state_d = ARB;
      end
      ARB: begin
        if (rr_found_c) begin
          sel_d   = rr_sel_c;
          ptr_d   = rr_sel_c;
          state_d = ROUTE;
        end else begin
          state_d = IDLE;
        end
      end
      ROUTE: begin
        dst_d = route_c;
        // Uses registered free_o so a same-cycle release is not seen yet
        if (free_o[route_c]) begin
          ack_d[sel_q] = 1'b1;
          state_d      = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        free_d[dst_q]    = 1'b0;
        outport_d[dst_q] = sel_q;
        inport_d[sel_q]  = dst_q;
        active_d[sel_q]  = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      sel_q     <= EAST;
      ptr_q     <= LOCAL;
      dst_q     <= EAST;
      active_q  <= '0;
      sending_q <= '0;
      ack_h_o   <= '0;
      free_o    <= '1;
      inport_o  <= '0;
      outport_o <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      dst_q     <= dst_d;
      active_q  <= active_d;
      sending_q <= sending_i;
      ack_h_o   <= ack_d;
      free_o    <= free_d;
      inport_o  <= inport_d;
      outport_o <= outport_d;
    end
  end

endmodule

// File: tb/tb_hermes_switch_control.sv
// Bench for hermes_switch_control: routing vector table, directed corner sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_hermes_switch_control;

  localparam int NP = 5;
  localparam int E = 0, W = 1, N = 2, S = 3, L = 4;

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic [15:0]           address_i = '0;
  logic [NP-1:0]         req_i = '0;
  logic [NP-1:0][31:0]   header_i = '0;
  logic [NP-1:0]         sending_i = '0;
  logic [NP-1:0]         ack_h_o;
  logic [NP-1:0]         free_o;
  logic [NP-1:0][2:0]    inport_o;
  logic [NP-1:0][2:0]    outport_o;

  hermes_switch_control dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .address_i(address_i), .req_i(req_i),
    .header_i(header_i), .sending_i(sending_i), .ack_h_o(ack_h_o),
    .free_o(free_o), .inport_o(inport_o), .outport_o(outport_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [NP-1:0]      exp_ack, exp_free, m_active, m_sq;
  logic [NP-1:0][2:0] exp_inport, exp_outport;
  int                 m_ptr;
  bit                 m_run;

  typedef struct {
    logic [7:0] ax, ay, tx, ty;
    int         src, dst;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] hdr(input int x, input int y);
    logic [31:0] r;
    r = $urandom();
    r[15:8] = 8'(x);
    r[7:0]  = 8'(y);
    return r;
  endfunction

  function automatic int xy(input logic [15:0] a, input logic [31:0] h);
    int dx, dy;
    dx = int'(h[15:8]) - int'(a[15:8]);
    dy = int'(h[7:0]) - int'(a[7:0]);
    if (dx > 0) return E;
    if (dx < 0) return W;
    if (dy > 0) return N;
    if (dy < 0) return S;
    return L;
  endfunction

  task automatic wait_ack(input int lim, output int lat, output logic [NP-1:0] av);
    lat = 0;
    av  = '0;
    for (int c = 1; c <= lim; c++) begin
      @(negedge clk_i);
      if (ack_h_o != '0) begin
        lat = c;
        av  = ack_h_o;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_ni    = 1'b0;
    req_i     = '0;
    sending_i = '0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // One clock edge of the model: releases, then the caller applies its own action
  task automatic m_tick(output logic [NP-1:0] r, output logic [NP-1:0] pf);
    @(posedge clk_i);
    r  = req_i;
    pf = exp_free;
    for (int i = 0; i < NP; i++)
      if (m_active[i] && m_sq[i] && !sending_i[i]) begin
        exp_free[exp_inport[i]] = 1'b1;
        m_active[i] = 1'b0;
      end
    m_sq    = sending_i;
    exp_ack = '0;
  endtask

  // Each request takes an idle edge, an arbitration edge, a route edge and a grant edge
  task automatic model_thread();
    logic [NP-1:0] r, pf;
    int sel, dst;
    bit found;
    while (m_run) begin
      m_tick(r, pf);
      if (r == '0) continue;
      m_tick(r, pf);
      found = 0;
      sel   = 0;
      for (int k = 1; k <= NP; k++) begin
        int idx;
        idx = (m_ptr + k) % NP;
        if (!found && r[idx]) begin found = 1; sel = idx; end
      end
      if (!found) continue;
      m_ptr = sel;
      m_tick(r, pf);
      dst = xy(address_i, header_i[sel]);
      if (!pf[dst]) continue;
      exp_ack[sel] = 1'b1;
      m_tick(r, pf);
      exp_free[dst]    = 1'b0;
      exp_outport[dst] = 3'(sel);
      exp_inport[sel]  = 3'(dst);
      m_active[sel]    = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vt[11];
    int            lat;
    logic [NP-1:0] av;
    logic [NP-1:0] one;
    int            gcyc[$];
    logic [NP-1:0] gvec[$];
    int            len[NP];
    logic [7:0]    ax, ay;

    vt[0]  = '{8'd2,   8'd2,   8'd3,   8'd2,   L, E};
    vt[1]  = '{8'd2,   8'd2,   8'd1,   8'd2,   E, W};
    vt[2]  = '{8'd2,   8'd2,   8'd2,   8'd5,   W, N};
    vt[3]  = '{8'd2,   8'd2,   8'd2,   8'd0,   N, S};
    vt[4]  = '{8'd2,   8'd2,   8'd2,   8'd2,   S, L};
    vt[5]  = '{8'd0,   8'd0,   8'd255, 8'd0,   L, E};
    vt[6]  = '{8'd255, 8'd255, 8'd0,   8'd255, L, W};
    vt[7]  = '{8'd7,   8'd0,   8'd7,   8'd200, E, N};
    vt[8]  = '{8'd7,   8'd200, 8'd7,   8'd199, W, S};
    vt[9]  = '{8'd5,   8'd5,   8'd4,   8'd9,   N, W};
    vt[10] = '{8'd5,   8'd5,   8'd6,   8'd0,   S, E};

    // Reset state
    address_i = {8'd2, 8'd2};
    repeat (3) @(negedge clk_i);
    check("reset_free", free_o, 5'h1f);
    check("reset_ack", ack_h_o, 0);
    check("reset_inport", inport_o, 0);
    check("reset_outport", outport_o, 0);
    rst_ni = 1'b1;
    repeat (5) @(negedge clk_i);
    check("idle_noack", ack_h_o, 0);

    // Single-request routing table
    for (int v = 0; v < 11; v++) begin
      address_i = {vt[v].ax, vt[v].ay};
      header_i[vt[v].src] = hdr(vt[v].tx, vt[v].ty);
      req_i[vt[v].src] = 1'b1;
      one = 5'(1) << vt[v].src;
      wait_ack(10, lat, av);
      check($sformatf("v%0d_latency", v), lat, 3);
      check($sformatf("v%0d_ack", v), av, one);
      req_i[vt[v].src] = 1'b0;
      sending_i[vt[v].src] = 1'b1;
      @(negedge clk_i);
      check($sformatf("v%0d_free", v), free_o, 5'h1f & ~(5'(1) << vt[v].dst));
      check($sformatf("v%0d_outport", v), outport_o[vt[v].dst], vt[v].src);
      check($sformatf("v%0d_inport", v), inport_o[vt[v].src], vt[v].dst);
      @(negedge clk_i);
      sending_i[vt[v].src] = 1'b0;
      @(negedge clk_i);
      check($sformatf("v%0d_release", v), free_o, 5'h1f);
    end

    // Round robin among WEST, NORTH, LOCAL with distinct free destinations
    do_reset();
    address_i   = {8'd2, 8'd2};
    header_i[W] = hdr(3, 2);
    header_i[N] = hdr(1, 2);
    header_i[L] = hdr(2, 3);
    req_i = 5'b10110;
    for (int c = 1; c <= 20 && gvec.size() < 3; c++) begin
      @(negedge clk_i);
      if (ack_h_o != '0) begin
        gcyc.push_back(c);
        gvec.push_back(ack_h_o);
        for (int i = 0; i < NP; i++)
          if (ack_h_o[i]) begin req_i[i] = 1'b0; sending_i[i] = 1'b1; end
      end
    end
    check("rr_count", gvec.size(), 3);
    if (gvec.size() == 3) begin
      check("rr_first", gvec[0], 5'b00010);
      check("rr_second", gvec[1], 5'b00100);
      check("rr_third", gvec[2], 5'b10000);
      check("rr_lat", gcyc[0], 3);
      check("rr_gap1", gcyc[1] - gcyc[0], 4);
      check("rr_gap2", gcyc[2] - gcyc[1], 4);
    end
    @(negedge clk_i);
    check("rr_free", free_o, 5'b11000);
    check("rr_out_e", outport_o[E], W);
    check("rr_out_w", outport_o[W], N);
    check("rr_out_n", outport_o[N], L);

    // Two inputs release in the same cycle
    repeat (3) @(negedge clk_i);
    sending_i[W] = 1'b0;
    sending_i[N] = 1'b0;
    @(negedge clk_i);
    check("dual_release", free_o, 5'b11011);
    sending_i[L] = 1'b0;
    @(negedge clk_i);
    check("last_release", free_o, 5'h1f);

    // Contention: EAST and SOUTH both target LOCAL
    do_reset();
    header_i[E] = hdr(2, 2);
    header_i[S] = hdr(2, 2);
    req_i = 5'b01001;
    wait_ack(10, lat, av);
    check("cont_lat", lat, 3);
    check("cont_first", av, 5'b00001);
    req_i[E] = 1'b0;
    sending_i[E] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      check("cont_noack", ack_h_o, 0);
    end
    sending_i[E] = 1'b0;
    @(negedge clk_i);
    check("cont_freed", free_o[L], 1);
    wait_ack(12, lat, av);
    check("cont_second", av, 5'b01000);
    req_i[S] = 1'b0;
    sending_i[S] = 1'b1;
    @(negedge clk_i);
    check("cont_outport", outport_o[L], S);
    check("cont_inport", inport_o[S], L);
    check("cont_busy", free_o[L], 0);
    sending_i[S] = 1'b0;
    @(negedge clk_i);

    // Asynchronous reset during GRANT of NORTH
    do_reset();
    header_i[N] = hdr(3, 2);
    req_i[N] = 1'b1;
    repeat (2) @(negedge clk_i);
    @(posedge clk_i);
    #1;
    check("rst_pre_ack", ack_h_o, 5'b00100);
    rst_ni = 1'b0;
    #1;
    check("rst_ack", ack_h_o, 0);
    check("rst_free", free_o, 5'h1f);
    req_i = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);
    check("rst_after_ack", ack_h_o, 0);
    check("rst_after_free", free_o, 5'h1f);

    // Randomized traffic against the reference model
    rst_ni    = 1'b0;
    req_i     = '0;
    sending_i = '0;
    ax = 8'($urandom_range(1, 254));
    ay = 8'($urandom_range(1, 254));
    address_i = {ax, ay};
    exp_ack = '0; exp_free = '1; exp_inport = '0; exp_outport = '0;
    m_active = '0; m_sq = '0; m_ptr = L; m_run = 1;
    for (int i = 0; i < NP; i++) len[i] = 0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    fork
      model_thread();
      begin
        for (int c = 0; c < 3000; c++) begin
          @(negedge clk_i);
          check("rnd_ack", ack_h_o, exp_ack);
          check("rnd_free", free_o, exp_free);
          for (int o = 0; o < NP; o++)
            if (!exp_free[o]) check($sformatf("rnd_outport%0d", o), outport_o[o], exp_outport[o]);
          for (int i = 0; i < NP; i++)
            if (m_active[i]) check($sformatf("rnd_inport%0d", i), inport_o[i], exp_inport[i]);
          for (int i = 0; i < NP; i++) begin
            if (ack_h_o[i]) begin
              req_i[i] = 1'b0;
              sending_i[i] = 1'b1;
              len[i] = $urandom_range(1, 10);
            end else if (sending_i[i]) begin
              len[i]--;
              if (len[i] <= 0) sending_i[i] = 1'b0;
            end else if (!req_i[i] && $urandom_range(0, 3) == 0) begin
              int tx, ty;
              case ($urandom_range(0, 3))
                0: tx = ax - 1;  1: tx = ax;  2: tx = ax + 1;  default: tx = $urandom_range(0, 255);
              endcase
              case ($urandom_range(0, 3))
                0: ty = ay - 1;  1: ty = ay;  2: ty = ay + 1;  default: ty = $urandom_range(0, 255);
              endcase
              header_i[i] = hdr(tx, ty);
              req_i[i] = 1'b1;
            end
          end
        end
        m_run = 0;
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
